// File: rtl/imem_boot_ctrl_pkg.sv
// Shared constants for the rv32i instruction-path boot sequencer.
// Holds the datapath width, the fetch start address, the instruction BRAM
// depth and the boot sequencer state encodings.
package imem_boot_ctrl_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam logic [31:0] BOOT_ADDR = 32'h0000_0000;
    localparam int I_BRAM_DEPTH = 256;

    // Boot sequencer states, kept as plain 2-bit constants so existing
    // logic that decodes the state bus keeps working.
    localparam logic [1:0] BOOT_IDLE  = 2'd0;
    localparam logic [1:0] BOOT_LOAD  = 2'd1;
    localparam logic [1:0] BOOT_PRIME = 2'd2;
    localparam logic [1:0] BOOT_RUN   = 2'd3;

endpackage

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: loads a program from a valid/ready word stream into the
// instruction BRAM write port, primes the BRAM read port for one cycle and
// then releases the PC stall so fetch starts at BOOT_ADDR.
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN adds exp_sum/sum_out and
// rejects a load whose modulo-2^32 word sum does not match exp_sum.
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DEPTH_WORDS = I_BRAM_DEPTH,
    parameter int LEN_W       = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  halt,
    input  logic [LEN_W-1:0]      prog_len,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
`ifdef IMEM_BOOT_CHECKSUM_EN
    input  logic [DATA_WIDTH-1:0] exp_sum,
    output logic [DATA_WIDTH-1:0] sum_out,
`endif
    output logic                  s_ready,
    output logic [ADDR_W-1:0]     w_addr,
    output logic [DATA_WIDTH-1:0] w_dat,
    output logic                  w_enb,
    output logic                  r_enb,
    output logic                  pc_stall,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH_WORDS);

    logic [1:0]       state;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] count_inc;
    logic             accept;
    logic             sum_ok;

    assign accept    = s_valid && s_ready;
    assign count_inc = count + LEN_W'(1);

`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] sum_ref;

    assign sum_ok  = (sum == sum_ref);
    assign sum_out = sum;

    // Running sum of accepted words; the reference is captured at start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum     <= '0;
            sum_ref <= '0;
        end else if (!halt && state == BOOT_IDLE && start) begin
            sum     <= '0;
            sum_ref <= exp_sum;
        end else if (!halt && state == BOOT_LOAD && accept) begin
            sum <= sum + s_data;
        end
    end
`else
    assign sum_ok = 1'b1;
`endif

    // Boot sequencer: state, load counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register here uses <= so all updates see pre-edge values.
        if (rst) begin
            state    <= BOOT_IDLE;
            count    <= '0;
            len      <= '0;
            w_addr   <= '0;
            w_dat    <= '0;
            w_enb    <= 1'b0;
            r_enb    <= 1'b0;
            pc_stall <= 1'b1;
            s_ready  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // A write strobe lasts one cycle unless a word is accepted again.
            w_enb <= 1'b0;
            if (halt) begin
                state    <= BOOT_IDLE;
                s_ready  <= 1'b0;
                r_enb    <= 1'b0;
                pc_stall <= 1'b1;
                busy     <= 1'b0;
                done     <= 1'b0;
            end else begin
                case (state)
                    BOOT_IDLE: begin
                        if (start) begin
                            if (prog_len > DEPTH_L) begin
                                err <= 1'b1;
                            end else begin
                                err   <= 1'b0;
                                len   <= prog_len;
                                count <= '0;
                                busy  <= 1'b1;
                                if (prog_len == '0) begin
                                    state <= BOOT_PRIME;
                                    r_enb <= 1'b1;
                                end else begin
                                    state   <= BOOT_LOAD;
                                    s_ready <= 1'b1;
                                end
                            end
                        end
                    end
                    BOOT_LOAD: begin
                        if (accept) begin
                            w_enb   <= 1'b1;
                            w_addr  <= {count[ADDR_W-3:0], 2'b00};
                            w_dat   <= s_data;
                            count   <= count_inc;
                            s_ready <= (count_inc < len);
                        end else if (count == len) begin
                            // Last write is on the port this cycle; leave next edge.
                            if (sum_ok) begin
                                state <= BOOT_PRIME;
                                r_enb <= 1'b1;
                            end else begin
                                state <= BOOT_IDLE;
                                err   <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    BOOT_PRIME: begin
                        state    <= BOOT_RUN;
                        pc_stall <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                    default: begin
                        // BOOT_RUN: hold until halt; start is ignored.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl. Holds a small BRAM + PC harness,
// a write scoreboard fed by the stream driver, and directed scenarios.
// Define IMEM_BOOT_CHECKSUM_EN to also exercise the checksum feature.
module tb_imem_boot_ctrl;
    import imem_boot_ctrl_pkg::*;

    localparam int ADDR_W      = 10;
    localparam int DEPTH_WORDS = 256;
    localparam int LEN_W       = 9;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  halt;
    logic [LEN_W-1:0]      prog_len;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic [ADDR_W-1:0]     w_addr;
    logic [DATA_WIDTH-1:0] w_dat;
    logic                  w_enb;
    logic                  r_enb;
    logic                  pc_stall;
    logic                  busy;
    logic                  done;
    logic                  err;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] exp_sum;
    logic [DATA_WIDTH-1:0] sum_out;
`endif

    imem_boot_ctrl #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH_WORDS), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .halt     (halt),
        .prog_len (prog_len),
        .s_valid  (s_valid),
        .s_data   (s_data),
`ifdef IMEM_BOOT_CHECKSUM_EN
        .exp_sum  (exp_sum),
        .sum_out  (sum_out),
`endif
        .s_ready  (s_ready),
        .w_addr   (w_addr),
        .w_dat    (w_dat),
        .w_enb    (w_enb),
        .r_enb    (r_enb),
        .pc_stall (pc_stall),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- BRAM + PC harness (bram32 / pc stand-in) ----------------
    logic [31:0] bram [DEPTH_WORDS];
    logic [31:0] pc = 32'h0;
    logic [31:0] r_dat = 32'h0;
    logic [31:0] pc_next;

    assign pc_next = pc_stall ? pc : pc + 32'd4;

    always @(posedge clk) begin
        if (w_enb) bram[w_addr[ADDR_W-1:2]] <= w_dat;
        if (rst || start) pc <= BOOT_ADDR;
        else              pc <= pc_next;
        if (r_enb) r_dat <= bram[pc_next[ADDR_W-1:2]];
    end

    // ---------------- Model: expected writes and expected program image ----------------
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t               exp_q[$];
    wr_t               e_wr;
    logic [31:0]       prog [DEPTH_WORDS];
    logic [31:0]       img  [DEPTH_WORDS];
    int                n_img = 0;
    int                w_cnt = 0;
    int                last_w_cyc = 0;
    logic [ADDR_W-1:0] last_w_addr = '0;
    int                wcyc_q[$];
    logic [ADDR_W-1:0] waddr_q[$];
    int                prime_cnt = 0;
    int                done_cyc = 0;

    // Compare process: every cycle out of reset, check writes against the
    // scoreboard, fetched words against the image, and output relations.
    always @(negedge clk) begin
        if (!rst) begin
            if (w_enb) begin
                if (exp_q.size() == 0) begin
                    check_b("unexpected_write", w_enb, 1'b0);
                end else begin
                    e_wr = exp_q.pop_front();
                    check("w_addr", 32'(w_addr), 32'(e_wr.addr));
                    check("w_dat", w_dat, e_wr.data);
                end
                w_cnt++;
                last_w_cyc  = cyc;
                last_w_addr = w_addr;
                wcyc_q.push_back(cyc);
                waddr_q.push_back(w_addr);
            end
            check_b("stall_is_not_done", pc_stall, !done);
            check_b("busy_done_exclusive", busy && done, 1'b0);
            check_b("write_only_when_busy", w_enb && !busy, 1'b0);
            check_b("ready_only_when_busy", s_ready && !busy, 1'b0);
            check_b("run_reads_bram", done && !r_enb, 1'b0);
            if (done && int'(pc >> 2) < n_img)
                check("fetch_word", r_dat, img[int'(pc >> 2)]);
            if (busy && r_enb && pc_stall) prime_cnt++;
        end
    end

    // ---------------- Driver tasks (all start and end on a negedge) ----------------
    task automatic clear_stats();
        w_cnt = 0;
        prime_cnt = 0;
        wcyc_q.delete();
        waddr_q.delete();
    endtask

    task automatic start_load(input int len);
        prog_len = LEN_W'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_halt();
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
    endtask

    // Offer prog[0..n-1]; stop after stop_after accepted words. toggle inserts
    // a gap cycle after each offered word.
    task automatic stream(input int n, input bit toggle, input int stop_after);
        int idx = 0;
        int budget = 0;
        bit phase = 1'b0;
        n_img = 0;
        while (idx < stop_after && budget < 4 * n + 20) begin
            if (toggle && phase) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = prog[idx];
            end
            phase = !phase;
            if (s_valid && s_ready) begin
                exp_q.push_back('{addr: ADDR_W'(idx * 4), data: prog[idx]});
                img[idx] = prog[idx];
                idx++;
                n_img = idx;
            end
            @(negedge clk);
            budget++;
        end
        s_valid = 1'b0;
        if (idx < stop_after) check("stream_accepted", 32'(idx), 32'(stop_after));
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_b("done_reached", done, 1'b1);
        done_cyc = cyc;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; halt = 1'b0; prog_len = '0;
        s_valid = 1'b0; s_data = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
        exp_sum = '0;
`endif
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h0030_0113;
        prog[2] = 32'h0020_81b3;
        prog[3] = 32'h0000_0013;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values.
        check_b("rst_s_ready", s_ready, 1'b0);
        check_b("rst_w_enb", w_enb, 1'b0);
        check_b("rst_r_enb", r_enb, 1'b0);
        check_b("rst_pc_stall", pc_stall, 1'b1);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_done", done, 1'b0);
        check_b("rst_err", err, 1'b0);
        check("rst_w_addr", 32'(w_addr), 32'h0);
        check("rst_w_dat", w_dat, 32'h0);

        // T1: four words back-to-back, prime, run.
        clear_stats();
        start_load(4);
        check_b("t1_ready_after_start", s_ready, 1'b1);
        stream(4, 1'b0, 4);
        wait_done(10);
        check("t1_writes", 32'(w_cnt), 32'd4);
        check("t1_last_addr", 32'(last_w_addr), 32'h0000_000C);
        check("t1_prime_cycles", 32'(prime_cnt), 32'd1);
        check("t1_done_latency", 32'(done_cyc - last_w_cyc), 32'd2);
        check("t1_first_fetch", r_dat, 32'h0050_0093);
        check("t1_first_pc", pc, 32'h0);
        repeat (3) @(negedge clk);
        check("t1_pc_c", pc, 32'h0000_000C);
        check("t1_fetch_c", r_dat, 32'h0000_0013);
        pulse_halt();
        check_b("t1_halt_stall", pc_stall, 1'b1);
        check_b("t1_halt_done", done, 1'b0);
        check_b("t1_halt_r_enb", r_enb, 1'b0);

        // T2: same load with s_valid toggling 1,0,1,0.
        clear_stats();
        start_load(4);
        stream(4, 1'b1, 4);
        wait_done(10);
        check("t2_writes", 32'(w_cnt), 32'd4);
        for (int i = 0; i < 3; i++)
            check("t2_write_spacing", 32'(wcyc_q[i+1] - wcyc_q[i]), 32'd2);
        check("t2_done_latency", 32'(done_cyc - last_w_cyc), 32'd2);
        check("t2_last_addr", 32'(last_w_addr), 32'h0000_000C);
        pulse_halt();

        // T3: oversize program is rejected.
        clear_stats();
        start_load(257);
        check_b("t3_err", err, 1'b1);
        check_b("t3_ready", s_ready, 1'b0);
        check_b("t3_stall", pc_stall, 1'b1);
        check_b("t3_busy", busy, 1'b0);
        @(negedge clk);
        check_b("t3_still_idle", busy || done, 1'b0);

        // T4: halt after 2 of 4 words, then reload a new program from 0x0.
        clear_stats();
        start_load(4);
        check_b("t4_err_cleared", err, 1'b0);
        stream(4, 1'b0, 2);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check_b("t4_halt_ready", s_ready, 1'b0);
        check_b("t4_halt_stall", pc_stall, 1'b1);
        check_b("t4_halt_busy", busy, 1'b0);
        check_b("t4_halt_w_enb", w_enb, 1'b0);
        check("t4_partial_writes", 32'(w_cnt), 32'd2);
        for (int i = 0; i < 4; i++) prog[i] = 32'hA500_0000 + 32'(i);
        clear_stats();
        start_load(4);
        stream(4, 1'b0, 4);
        wait_done(10);
        check("t4_reload_first_addr", 32'(waddr_q[0]), 32'h0);
        check("t4_reload_writes", 32'(w_cnt), 32'd4);
        check("t4_reload_fetch0", r_dat, 32'hA500_0000);
        pulse_halt();

        // T5: start and halt together in IDLE.
        halt = 1'b1; start = 1'b1; prog_len = LEN_W'(4);
        @(negedge clk);
        halt = 1'b0; start = 1'b0;
        check_b("t5_busy", busy, 1'b0);
        check_b("t5_ready", s_ready, 1'b0);
        @(negedge clk);
        check_b("t5_busy_later", busy, 1'b0);
        check_b("t5_stall", pc_stall, 1'b1);

        // T6: zero-length program goes straight to PRIME.
        clear_stats();
        n_img = 0;
        start_load(0);
        check_b("t6_prime_busy", busy, 1'b1);
        check_b("t6_prime_r_enb", r_enb, 1'b1);
        check_b("t6_prime_stall", pc_stall, 1'b1);
        check_b("t6_prime_ready", s_ready, 1'b0);
        @(negedge clk);
        check_b("t6_run", done, 1'b1);
        check("t6_no_writes", 32'(w_cnt), 32'd0);
        pulse_halt();

        // T7: full-depth program (256 words), top address 0x3FC.
        for (int i = 0; i < DEPTH_WORDS; i++) prog[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
        clear_stats();
        start_load(256);
        check_b("t7_no_err", err, 1'b0);
        stream(256, 1'b0, 256);
        wait_done(10);
        check("t7_writes", 32'(w_cnt), 32'd256);
        check("t7_last_addr", 32'(last_w_addr), 32'h0000_03FC);
        repeat (4) @(negedge clk);
        pulse_halt();

        // T8: reset asserted mid-LOAD returns outputs to reset values at once.
        clear_stats();
        start_load(4);
        stream(4, 1'b0, 2);
        @(negedge clk);
        check_b("t8_mid_load_ready", s_ready, 1'b1);
        rst = 1'b1;
        #1;
        check_b("t8_rst_ready", s_ready, 1'b0);
        check_b("t8_rst_busy", busy, 1'b0);
        check_b("t8_rst_stall", pc_stall, 1'b1);
        check("t8_rst_w_addr", 32'(w_addr), 32'h0);
        @(negedge clk);
        exp_q.delete();
        rst = 1'b0;

`ifdef IMEM_BOOT_CHECKSUM_EN
        // T9: checksum match and mismatch.
        for (int i = 0; i < 4; i++) prog[i] = 32'(i + 1);
        clear_stats();
        exp_sum = 32'd10;
        start_load(4);
        stream(4, 1'b0, 4);
        wait_done(10);
        check("t9_sum_out", sum_out, 32'd10);
        check_b("t9_err_ok", err, 1'b0);
        pulse_halt();
        clear_stats();
        exp_sum = 32'd11;
        start_load(4);
        stream(4, 1'b0, 4);
        @(negedge clk);
        check_b("t9_bad_err", err, 1'b1);
        check_b("t9_bad_busy", busy, 1'b0);
        check_b("t9_bad_stall", pc_stall, 1'b1);
        check_b("t9_bad_r_enb", r_enb, 1'b0);
        @(negedge clk);
        check_b("t9_bad_done", done, 1'b0);
`endif

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Boot sequencer for the rv32i single-cycle core's instruction path.
- After reset it accepts a program as a valid/ready word stream and writes it into the instruction BRAM (bram32) write port at 4-byte-aligned addresses.
- It then primes the BRAM read port for one cycle and releases the PC stall so fetch begins at BOOT_ADDR.
- It sits between the external program source (testbench/AXI bridge) and the pc/bram32 pair, and replaces hand-driven w_addr/w_enb/pc_stall/r_enb sequencing.

Parameters:
- ADDR_W, 10, byte-address width of BRAM write port (matches bram32 w_addr).
- DEPTH_WORDS, 256, max program length in words (2^(ADDR_W-2)).
- LEN_W, 9, width of prog_len (holds 0..DEPTH_WORDS).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begin a load, sampling prog_len.
- halt  in  1  return to IDLE (stalls the core) from any state.
- prog_len  in  LEN_W  number of words to load.
- s_valid  in  1  program word valid.
- s_data  in  `DATA_WIDTH  program word.
- s_ready  out  1  controller accepts s_data this cycle.
- w_addr  out  ADDR_W  BRAM write byte address.
- w_dat  out  `DATA_WIDTH  BRAM write data.
- w_enb  out  1  BRAM write enable. byte_enb is tied to 4'b1111 externally.
- r_enb  out  1  BRAM read enable.
- pc_stall  out  1  stall to pc.
- busy  out  1  state is LOAD or PRIME.
- done  out  1  state is RUN.
- err  out  1  sticky; prog_len > DEPTH_WORDS at start.

Behaviour:
- Reset values: state=IDLE, count=0, w_addr=0, w_dat=0, w_enb=0, r_enb=0, pc_stall=1, s_ready=0, busy=0, done=0, err=0. All outputs are registered.
- IDLE:
  - pc_stall=1, r_enb=0.
  - start with prog_len<=DEPTH_WORDS: count:=0, latch len, clear err, go to LOAD.
  - start with prog_len>DEPTH_WORDS: err:=1, stay in IDLE.
  - start with prog_len==0: go directly to PRIME.
- LOAD:
  - s_ready=1 iff count<len.
  - On s_valid&&s_ready: next cycle w_enb=1, w_addr=count<<2, w_dat=s_data; count++.
  - Gaps in s_valid give w_enb=0 with w_addr held.
  - When the final word is accepted (count reaches len), s_ready drops the following cycle; the state moves to PRIME one cycle after the last write is issued. This guarantees the write completes before any read.
- PRIME (exactly 1 cycle): w_enb=0, r_enb=1, pc_stall=1. This covers bram32's 1-cycle read latency so the instruction at BOOT_ADDR is valid when the stall releases.
- RUN: pc_stall=0, r_enb=1, done=1. start is ignored. Remains here until halt.
- halt (any state): next cycle state=IDLE, pc_stall=1, r_enb=0, w_enb=0, s_ready=0. A partial load is abandoned; written words are not erased.
- halt and start in the same cycle: halt wins; start is dropped.
- Write address width rule: w_addr = {count[ADDR_W-3:0],2'b00}. count never exceeds len, so there is no wrap.
- Reset asserted mid-LOAD: immediate return to reset values. BRAM contents are unspecified afterwards.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- When defined:
  - Extra input exp_sum [`DATA_WIDTH] is sampled at start.
  - A 32-bit modulo-2^32 sum of accepted words is accumulated.
  - On leaving LOAD, sum!=exp_sum sets err:=1 and the state goes to IDLE instead of PRIME (core stays stalled).
  - Extra output sum_out reports the running sum.
- When undefined: no exp_sum/sum_out ports, and LOAD always proceeds to PRIME.

Decomposition:
- Shared package/header rv32i_params.vh: DATA_WIDTH, BOOT_ADDR, I_BRAM_DEPTH, and new state encodings BOOT_IDLE=2'd0, BOOT_LOAD=2'd1, BOOT_PRIME=2'd2, BOOT_RUN=2'd3.
- No sub-module required; the checksum accumulator is inline under the macro.

Test Plan:
- start, prog_len=4, stream 4 words of add_registers.new.hex back-to-back:
  - w_enb pulses at addresses 0x0,0x4,0x8,0xC;
  - one PRIME cycle;
  - pc_stall falls;
  - bram32 r_dat equals init_mem[0..3] on consecutive cycles, with pc=0,4,8,C.
- Same load with s_valid toggling 1,0,1,0:
  - exactly 4 writes, at correct addresses;
  - w_enb low on gap cycles;
  - done only after the 4th write.
- start with prog_len=257: err=1, state stays IDLE, s_ready=0, pc_stall=1.
- halt asserted after 2 of 4 words: next cycle s_ready=0, pc_stall=1, busy=0. A following start with prog_len=4 reloads from address 0x0.
- start and halt together in IDLE: no transition, busy stays 0.
- With IMEM_BOOT_CHECKSUM_EN, words 1,2,3,4 and exp_sum=10: reaches RUN. Repeat with exp_sum=11: err=1, IDLE, pc_stall=1.
